// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types, frame constants and helpers for the UART PHY.
// Contents: TX/RX state enums, bit-period helper, parity helper.
// Used by uart_phy. The optional parity bit is enabled with UART_PARITY_EN.
package uart_pkg;

  localparam int unsigned DATA_BITS   = 8;
  localparam int unsigned PARITY_EVEN = 1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  // Clock cycles per serial bit (integer division).
  function automatic int unsigned clks_per_bit(input int unsigned freq,
                                               input int unsigned baud);
    return freq / baud;
  endfunction

  // Parity bit sent with a byte; even parity makes the 9-bit group XOR to 0.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] data);
    return (^data) ^ (PARITY_EVEN == 0);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer
// Loadable down-counter producing a one-cycle terminal-count pulse.
// Ports:
//   i_clk, i_reset  clock, asynchronous active-high reset
//   i_load          load i_load_val (takes priority over counting)
//   i_load_val      cycles to wait after the load cycle, minus one
//   o_tc_c          high for one cycle when the loaded count reaches zero
module uart_bit_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_tc_c
);

  logic [WIDTH-1:0] r_count;
  logic             r_active;

  // r_active limits the terminal count to one pulse per load.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count  <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_count  <= i_load_val;
      r_active <= 1'b1;
    end else if (r_count != '0) begin
      r_count  <= r_count - WIDTH'(1);
    end else begin
      r_active <= 1'b0;
    end
  end

  assign o_tc_c = r_active && (r_count == '0);

endmodule

// File: rtl/uart_phy.sv
// uart_phy
// UART line PHY: serialises bytes to o_uart_tx and deserialises i_uart_rx.
// Frame: start, 8 data bits LSB first, optional even parity, one stop bit.
// Optional feature macro: UART_PARITY_EN (adds the parity bit on TX and RX).
// Ports:
//   i_clk, i_reset      clock, asynchronous active-high reset
//   i_tx_data/i_tx_stb  byte and one-cycle send request (ignored while busy)
//   o_tx_busy           transmitter occupied
//   o_rx_data/o_rx_stb  received byte and one-cycle valid pulse
//   o_rx_frame_err      one-cycle pulse on a low stop bit
//   o_rx_parity_err     one-cycle pulse on parity mismatch (0 without parity)
//   i_uart_rx/o_uart_tx serial pins
module uart_phy
  import uart_pkg::*;
#(
  parameter int unsigned I_CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE    = 115200
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_stb,
  output logic                 o_tx_busy,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_stb,
  output logic                 o_rx_frame_err,
  output logic                 o_rx_parity_err,
  input  logic                 i_uart_rx,
  output logic                 o_uart_tx
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(I_CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned TW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_phy: I_CLOCK_FREQ / BAUD_RATE must be at least 4");
  end

  // ---------------------------------------------------------------- TX
  tx_state_t            r_tx_state;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic [BW-1:0]        r_tx_cnt;
  logic                 r_tx_line;
  logic                 r_tx_busy;
  logic                 w_tx_tc;
  logic                 w_tx_load;
`ifdef UART_PARITY_EN
  logic                 r_tx_par;
`endif

  // Busy is low only in TX_IDLE, so an accepted request and every bit
  // boundary both restart the bit timer.
  assign w_tx_load = (r_tx_state == TX_IDLE) ? i_tx_stb : w_tx_tc;

  uart_bit_timer #(.WIDTH(TW)) u_tx_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_tx_load),
    .i_load_val (BIT_LOAD),
    .o_tc_c     (w_tx_tc)
  );

  // TX FSM: the line register always holds the bit currently on the wire.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tx_state <= TX_IDLE;
      r_tx_shift <= '0;
      r_tx_cnt   <= '0;
      r_tx_line  <= 1'b1;
      r_tx_busy  <= 1'b0;
`ifdef UART_PARITY_EN
      r_tx_par   <= 1'b0;
`endif
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (i_tx_stb) begin
            r_tx_shift <= i_tx_data;
            r_tx_line  <= 1'b0;
            r_tx_busy  <= 1'b1;
            r_tx_state <= TX_START;
`ifdef UART_PARITY_EN
            r_tx_par   <= parity_bit(i_tx_data);
`endif
          end
        end
        TX_START: begin
          if (w_tx_tc) begin
            r_tx_line  <= r_tx_shift[0];
            r_tx_shift <= r_tx_shift >> 1;
            r_tx_cnt   <= '0;
            r_tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (w_tx_tc) begin
            if (r_tx_cnt == LAST_BIT) begin
`ifdef UART_PARITY_EN
              r_tx_line  <= r_tx_par;
              r_tx_state <= TX_PARITY;
`else
              r_tx_line  <= 1'b1;
              r_tx_state <= TX_STOP;
`endif
            end else begin
              r_tx_line  <= r_tx_shift[0];
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_cnt   <= r_tx_cnt + BW'(1);
            end
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (w_tx_tc) begin
            r_tx_line  <= 1'b1;
            r_tx_state <= TX_STOP;
          end
        end
`endif
        TX_STOP: begin
          if (w_tx_tc) begin
            r_tx_busy  <= 1'b0;
            r_tx_state <= TX_IDLE;
          end
        end
        default: begin
          r_tx_line  <= 1'b1;
          r_tx_busy  <= 1'b0;
          r_tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  assign o_uart_tx = r_tx_line;
  assign o_tx_busy = r_tx_busy;

  // ---------------------------------------------------------------- RX
  rx_state_t            r_rx_state;
  logic                 r_rx_meta;
  logic                 r_rx_sync;
  logic                 r_rx_prev;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic [BW-1:0]        r_rx_cnt;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_stb;
  logic                 r_rx_ferr;
  logic                 w_rx_tc;
  logic                 w_rx_fall;
  logic                 w_rx_load;
  logic [TW-1:0]        w_rx_load_val;
`ifdef UART_PARITY_EN
  logic                 r_rx_par;
  logic                 r_rx_perr;
`endif

  assign w_rx_fall = r_rx_prev & ~r_rx_sync;

  // Half a bit after the start edge lands on the start-bit centre; every
  // later sample is a full bit further on.
  always_comb begin
    w_rx_load     = 1'b0;
    w_rx_load_val = BIT_LOAD;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_load     = w_rx_fall;
        w_rx_load_val = HALF_LOAD;
      end
      RX_START, RX_DATA, RX_PARITY: w_rx_load = w_rx_tc;
      default:                      w_rx_load = 1'b0;
    endcase
  end

  uart_bit_timer #(.WIDTH(TW)) u_rx_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_rx_load),
    .i_load_val (w_rx_load_val),
    .o_tc_c     (w_rx_tc)
  );

  // RX synchroniser, edge detector and FSM; status outputs are single pulses.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_shift <= '0;
      r_rx_cnt   <= '0;
      r_rx_data  <= '0;
      r_rx_stb   <= 1'b0;
      r_rx_ferr  <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_par   <= 1'b0;
      r_rx_perr  <= 1'b0;
`endif
    end else begin
      r_rx_meta <= i_uart_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      r_rx_stb  <= 1'b0;
      r_rx_ferr <= 1'b0;
`ifdef UART_PARITY_EN
      r_rx_perr <= 1'b0;
`endif
      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_fall) r_rx_state <= RX_START;
        end
        RX_START: begin
          if (w_rx_tc) begin
            r_rx_cnt   <= '0;
            r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (w_rx_tc) begin
            r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
            r_rx_cnt   <= r_rx_cnt + BW'(1);
            if (r_rx_cnt == LAST_BIT) begin
`ifdef UART_PARITY_EN
              r_rx_state <= RX_PARITY;
`else
              r_rx_state <= RX_STOP;
`endif
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (w_rx_tc) begin
            r_rx_par   <= r_rx_sync;
            r_rx_state <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          if (w_rx_tc) begin
            if (!r_rx_sync) begin
              r_rx_ferr  <= 1'b1;
              r_rx_state <= RX_BREAK;
`ifdef UART_PARITY_EN
            end else if (r_rx_par != parity_bit(r_rx_shift)) begin
              r_rx_perr  <= 1'b1;
              r_rx_state <= RX_IDLE;
`endif
            end else begin
              r_rx_data  <= r_rx_shift;
              r_rx_stb   <= 1'b1;
              r_rx_state <= RX_IDLE;
            end
          end
        end
        // A low stop bit may be a break; wait for the line to idle high.
        RX_BREAK: begin
          if (r_rx_sync) r_rx_state <= RX_IDLE;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign o_rx_data      = r_rx_data;
  assign o_rx_stb       = r_rx_stb;
  assign o_rx_frame_err = r_rx_ferr;
`ifdef UART_PARITY_EN
  assign o_rx_parity_err = r_rx_perr;
`else
  assign o_rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_phy.sv
// tb_uart_phy
// Self-checking bench for uart_phy at 10 clocks per bit. TX waveforms are
// compared cycle by cycle against a frame model; received bytes are checked
// against a scoreboard queue filled before each frame is sent.
module tb_uart_phy;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int unsigned CPB    = CLK_HZ / BAUD;
`ifdef UART_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif
  // Pin fall -> o_rx_stb: 2 sync flops, half bit, remaining bits, output reg.
  localparam int unsigned RX_LAT = 2 + CPB / 2 + (FRAME_BITS - 1) * CPB + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data;
  logic       tx_stb;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_stb;
  logic       rx_ferr;
  logic       rx_perr;
  logic       rx_pin;
  logic       loop_en;
  logic       uart_rx;
  logic       uart_tx;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int stb_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int last_stb_cyc = -1;
  int tx_fall_cyc = 0;
  logic [7:0] exp_q[$];

  assign uart_rx = loop_en ? uart_tx : rx_pin;

  uart_phy #(
    .I_CLOCK_FREQ (CLK_HZ),
    .BAUD_RATE    (BAUD)
  ) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_tx_data       (tx_data),
    .i_tx_stb        (tx_stb),
    .o_tx_busy       (tx_busy),
    .o_rx_data       (rx_data),
    .o_rx_stb        (rx_stb),
    .o_rx_frame_err  (rx_ferr),
    .o_rx_parity_err (rx_perr),
    .i_uart_rx       (uart_rx),
    .o_uart_tx       (uart_tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line level of frame bit idx: start, d[0..7], optional parity, stop.
  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef UART_PARITY_EN
    if (idx == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Output monitor: scoreboard for received bytes, tallies of error pulses.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (rx_stb) begin
        stb_cnt++;
        last_stb_cyc = cyc;
        check_eq("rx_stb_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check_eq("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
      if (rx_ferr) ferr_cnt++;
      if (rx_perr) perr_cnt++;
    end
  end

  // Send d and check every cycle of the frame; optionally poke a second
  // request at relative cycle poke_cyc, which must be ignored.
  task automatic tx_frame(input logic [7:0] d, input int poke_cyc,
                          input logic [7:0] poke_d, input string tag);
    tx_data = d;
    tx_stb  = 1'b1;
    tick();
    tx_stb  = 1'b0;
    tx_fall_cyc = cyc;
    for (int c = 1; c <= int'(FRAME_BITS * CPB); c++) begin
      check_eq({tag, "_line"}, 32'(uart_tx), 32'(frame_bit(d, (c - 1) / int'(CPB))));
      check_eq({tag, "_busy"}, 32'(tx_busy), 32'd1);
      if (c == poke_cyc) begin
        tx_data = poke_d;
        tx_stb  = 1'b1;
      end
      tick();
      tx_stb = 1'b0;
    end
    check_eq({tag, "_done_busy"}, 32'(tx_busy), 32'd0);
    check_eq({tag, "_done_line"}, 32'(uart_tx), 32'd1);
  endtask

  // Drive a frame on the RX pin; a bad stop bit is held low stop_low cycles.
  task automatic rx_send(input logic [7:0] d, input logic stop_ok, input int stop_low);
    for (int b = 0; b < int'(FRAME_BITS) - 1; b++) begin
      rx_pin = frame_bit(d, b);
      repeat (CPB) tick();
    end
    if (!stop_ok) begin
      rx_pin = 1'b0;
      repeat (stop_low) tick();
    end
    rx_pin = 1'b1;
    repeat (CPB) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_stb;
    int base_ferr;
    logic [7:0] b;
    logic [7:0] loop_bytes[$];

    tx_data = 8'h00;
    tx_stb  = 1'b0;
    rx_pin  = 1'b1;
    loop_en = 1'b0;
    #1 rst = 1'b1;
    repeat (3) tick();

    // Reset state
    check_eq("rst_uart_tx",  32'(uart_tx), 32'd1);
    check_eq("rst_tx_busy",  32'(tx_busy), 32'd0);
    check_eq("rst_rx_stb",   32'(rx_stb),  32'd0);
    check_eq("rst_rx_ferr",  32'(rx_ferr), 32'd0);
    check_eq("rst_rx_perr",  32'(rx_perr), 32'd0);
    check_eq("rst_rx_data",  32'(rx_data), 32'd0);
    rst = 1'b0;
    repeat (3) tick();

    // Directed TX frames, ignored request while busy, back-to-back start
    tx_frame(8'hA5, -1, 8'h00, "tx_a5");
    tx_frame(8'h3C, 50, 8'hFF, "tx_3c");
    tx_frame(8'h11, -1, 8'h00, "tx_11");
    check_eq("tx_no_rx_activity", 32'(stb_cnt), 32'd0);
    repeat (5) tick();

    // Loopback: fixed corner bytes plus random ones
    loop_en = 1'b1;
    loop_bytes = '{8'h00, 8'hFF, 8'h5A};
    repeat (6) loop_bytes.push_back(8'($urandom_range(0, 255)));
    base_stb = stb_cnt;
    for (int i = 0; i < loop_bytes.size(); i++) begin
      b = loop_bytes[i];
      exp_q.push_back(b);
      tx_frame(b, -1, 8'h00, "loop_tx");
      check_eq("loop_stb_count", 32'(stb_cnt), 32'(base_stb + i + 1));
      check_eq("loop_rx_latency", 32'(last_stb_cyc - tx_fall_cyc), 32'(RX_LAT));
      repeat ($urandom_range(0, 15)) tick();
    end
    check_eq("loop_ferr", 32'(ferr_cnt), 32'd0);
    check_eq("loop_perr", 32'(perr_cnt), 32'd0);
    check_eq("loop_queue_empty", 32'(exp_q.size()), 32'd0);
    loop_en = 1'b0;
    repeat (5) tick();

    // Short low glitch is a false start
    base_stb  = stb_cnt;
    base_ferr = ferr_cnt;
    rx_pin = 1'b0;
    repeat (4) tick();
    rx_pin = 1'b1;
    repeat (3 * CPB) tick();
    check_eq("glitch_no_stb",  32'(stb_cnt),  32'(base_stb));
    check_eq("glitch_no_ferr", 32'(ferr_cnt), 32'(base_ferr));

    // Random frames straight on the pin, including one right after the glitch
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      rx_send(b, 1'b1, 0);
      repeat ($urandom_range(0, 12)) tick();
    end
    check_eq("pin_stb_count", 32'(stb_cnt), 32'(base_stb + 4));
    check_eq("pin_queue_empty", 32'(exp_q.size()), 32'd0);

    // Bad stop bit held low (break), then a good frame
    base_stb  = stb_cnt;
    base_ferr = ferr_cnt;
    rx_send(8'h42, 1'b0, 30);
    repeat (CPB) tick();
    check_eq("ferr_pulse_count", 32'(ferr_cnt), 32'(base_ferr + 1));
    check_eq("ferr_no_stb",      32'(stb_cnt),  32'(base_stb));
    check_eq("ferr_no_perr",     32'(perr_cnt), 32'd0);
    exp_q.push_back(8'h42);
    rx_send(8'h42, 1'b1, 0);
    repeat (5) tick();
    check_eq("after_ferr_stb",   32'(stb_cnt),  32'(base_stb + 1));
    check_eq("after_ferr_queue", 32'(exp_q.size()), 32'd0);
    check_eq("after_ferr_ferr",  32'(ferr_cnt), 32'(base_ferr + 1));

    // Asynchronous reset in the middle of data bit d[2]
    base_stb = stb_cnt;
    tx_data = 8'h00;
    tx_stb  = 1'b1;
    tick();
    tx_stb  = 1'b0;
    repeat (3 * CPB + 4) tick();
    check_eq("pre_rst_line", 32'(uart_tx), 32'(frame_bit(8'h00, 3)));
    check_eq("pre_rst_busy", 32'(tx_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_line", 32'(uart_tx), 32'd1);
    check_eq("async_rst_busy", 32'(tx_busy), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    tx_frame(8'hC3, -1, 8'h00, "tx_after_rst");
    check_eq("rst_no_partial_rx", 32'(stb_cnt), 32'(base_stb));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
